// File: rtl/instr_issue.sv
// -----------------------------------------------------------------------------
// instr_issue
//   Instruction issue queue in front of the 512-bit vector processor.
//   Buffers {opcode, entry1, entry2} instructions. Instructions whose memory
//   index is out of range are dropped on entry. Legal instructions are issued
//   in order, at most one per cycle. After each mul/sum, issue stalls for GAP
//   cycles so the ALU result in registers 2/3 can settle.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous clear of queue and gap counter
//   in_valid/in_ready upstream handshake; in_opcode/in_entry1/in_entry2 payload
//   out_ready         processor can take an instruction this cycle
//   issue_valid       one-cycle strobe; opcode/entry1/entry2 hold the new instr
//   count/empty/full  queue occupancy
//   drop_pulse        one cycle after an illegal instruction is discarded
//   drop_count        saturating (255) count of discarded instructions
// -----------------------------------------------------------------------------
module instr_issue #(
    parameter int DEPTH = 8,
    parameter int GAP   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_opcode,
    input  logic [9:0]               in_entry1,
    input  logic [1:0]               in_entry2,
    input  logic                     out_ready,
    output logic                     issue_valid,
    output logic [1:0]               opcode,
    output logic [9:0]               entry1,
    output logic [1:0]               entry2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     drop_pulse,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef struct packed {
        logic [1:0] op;
        logic [9:0] e1;
        logic [1:0] e2;
    } instr_t;

    instr_t          mem [DEPTH];
    instr_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap_cnt;
    logic            accept, push, drop, pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    // rst_n gates in_ready so nothing is advertised while held in reset
    assign in_ready = !full && !flush && rst_n;

    assign accept = in_valid && in_ready;
    // entry1 > 511 is exactly bit 9 set
    assign drop   = accept &&  in_entry1[9];
    assign push   = accept && !in_entry1[9];
    assign pop    = !empty && out_ready && (gap_cnt == '0) && !flush;
    assign head   = mem[rd_ptr];

    // storage needs no reset: occupancy is tracked by cnt
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{op: in_opcode, e1: in_entry1, e2: in_entry2};
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // mul (10) and sum (11) both have opcode[1] set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (flush)
            gap_cnt <= '0;
        else if (pop && head.op[1])
            gap_cnt <= GW'(GAP);
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
    end

    // issue register: fields hold their last value between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            opcode      <= '0;
            entry1      <= '0;
            entry2      <= '0;
        end else begin
            issue_valid <= pop;
            if (pop) begin
                opcode <= head.op;
                entry1 <= head.e1;
                entry2 <= head.e2;
            end
        end
    end

    // drop_count survives flush; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;

    localparam int DEPTH = 8;
    localparam int GAP   = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_ready;
    logic [1:0]  in_opcode, in_entry2;
    logic [9:0]  in_entry1;
    logic        issue_valid;
    logic [1:0]  opcode, entry2;
    logic [9:0]  entry1;
    logic [3:0]  count;
    logic        empty, full, drop_pulse;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_issue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_entry1(in_entry1), .in_entry2(in_entry2),
        .out_ready(out_ready), .issue_valid(issue_valid),
        .opcode(opcode), .entry1(entry1), .entry2(entry2),
        .count(count), .empty(empty), .full(full),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle so outputs are sampled away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [9:0] e1, input logic [1:0] e2);
        in_valid  = v;
        in_opcode = op;
        in_entry1 = e1;
        in_entry2 = e2;
    endtask

    initial begin
        int iv_pat;
        int n_iss;
        logic [9:0] iss_e1 [16];
        logic acc;
        logic any_iss;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'b00, 10'd3, 2'd0);

        // ---- reset ----
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_fields", {opcode, entry1, entry2}, 0);
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // ---- streaming ----
        drive(1'b1, 2'b00, 10'd5, 2'd0);
        step();
        chk("st_e1_count", count, 1);
        chk("st_e1_iv", issue_valid, 0);
        drive(1'b1, 2'b00, 10'd21, 2'd1);
        step();
        chk("st_e2_iv", issue_valid, 1);
        chk("st_e2_fields", {opcode, entry1, entry2}, {2'b00, 10'd5, 2'd0});
        chk("st_e2_count", count, 1);
        drive(1'b1, 2'b01, 10'd40, 2'd2);
        step();
        chk("st_e3_iv", issue_valid, 1);
        chk("st_e3_fields", {opcode, entry1, entry2}, {2'b00, 10'd21, 2'd1});
        chk("st_e3_count", count, 1);
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        step();
        chk("st_e4_iv", issue_valid, 1);
        chk("st_e4_fields", {opcode, entry1, entry2}, {2'b01, 10'd40, 2'd2});
        chk("st_e4_empty", empty, 1);
        step();
        chk("st_e5_iv", issue_valid, 0);
        chk("st_hold_fields", {opcode, entry1, entry2}, {2'b01, 10'd40, 2'd2});

        // ---- gap ----
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 10'd1, 2'd2); step();
        drive(1'b1, 2'b11, 10'd2, 2'd3); step();
        drive(1'b1, 2'b01, 10'd0, 2'd3); step();
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        out_ready = 1'b1;
        iv_pat = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            iv_pat = (iv_pat << 1) | int'(issue_valid);
            if (i == 0) chk("gap_mul", {opcode, entry1, entry2}, {2'b10, 10'd1, 2'd2});
            if (i == 3) chk("gap_sum", {opcode, entry1, entry2}, {2'b11, 10'd2, 2'd3});
            if (i == 6) chk("gap_store", {opcode, entry1, entry2}, {2'b01, 10'd0, 2'd3});
        end
        chk("gap_pattern", iv_pat, 32'b1001001000);

        // ---- full / backpressure ----
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b00, 10'(100 + i), 2'(i));
            step();
        end
        chk("full_flag", full, 1);
        chk("full_count", count, 8);
        chk("full_in_ready", in_ready, 0);
        drive(1'b1, 2'b00, 10'd108, 2'd0);
        step(); step();
        chk("full_hold_count", count, 8);
        chk("full_hold_iv", issue_valid, 0);
        out_ready = 1'b1;
        n_iss = 0;
        for (int k = 0; k < 20; k++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            if (k == 0) chk("full_drop_after_pop", full, 0);
            if (issue_valid && n_iss < 16) begin
                iss_e1[n_iss] = entry1;
                n_iss++;
            end
        end
        chk("full_n_issued", n_iss, 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("full_order_%0d", i), iss_e1[i], 100 + i);

        // ---- drop ----
        drive(1'b1, 2'b00, 10'd600, 2'd0);
        step();
        chk("drop_pulse_hi", drop_pulse, 1);
        chk("drop_cnt_1", drop_count, 1);
        chk("drop_not_queued", count, 0);
        drive(1'b1, 2'b00, 10'd511, 2'd1);
        step();
        chk("drop_pulse_lo", drop_pulse, 0);
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        step();
        chk("drop_511_iv", issue_valid, 1);
        chk("drop_511_e1", entry1, 511);
        drive(1'b1, 2'b00, 10'd1023, 2'd0);
        any_iss = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (issue_valid) any_iss = 1'b1;
        end
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        step();
        chk("drop_sat", drop_count, 255);
        chk("drop_none_issued", any_iss, 0);

        // ---- flush ----
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b00, 10'(200 + i), 2'd0);
            step();
        end
        chk("fl_count5", count, 5);
        drive(1'b1, 2'b00, 10'd7, 2'd0);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        chk("fl_count0", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_iv", issue_valid, 0);
        chk("fl_drop_kept", drop_count, 255);
        out_ready = 1'b1;
        any_iss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (issue_valid) any_iss = 1'b1;
        end
        chk("fl_lost", any_iss, 0);

        // ---- async reset mid-stream ----
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 10'(300 + i), 2'd3);
            step();
        end
        drive(1'b0, 2'b00, 10'd0, 2'd0);
        out_ready = 1'b1;
        step();
        chk("ar_pre_iv", issue_valid, 1);
        chk("ar_pre_e1", entry1, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_iv", issue_valid, 0);
        chk("ar_fields", {opcode, entry1, entry2}, 0);
        chk("ar_count", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_drop_count", drop_count, 0);
        chk("ar_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("ar_after_iv", issue_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue queue that sits directly upstream of the 512-bit vector processor. It buffers incoming `{opcode, entry1, entry2}` instructions and screens out those with an illegal memory index. It then presents valid instructions to the processor one per cycle, in order. After every `mul`/`sum` it inserts a programmable idle gap so the ALU result in registers 2/3 settles before the next instruction is issued.

## Interface
- `DEPTH`, 8: queue depth in instructions; power of 2, ≥2.
- `GAP`, 2: idle cycles forced after issuing a `mul` (2'b10) or `sum` (2'b11); 0 disables the gap.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  queue can accept; equals `!full && !flush && rst_n`.
- `in_opcode`  in  2  00 load, 01 store, 10 mul, 11 sum.
- `in_entry1`  in  10  memory word index.
- `in_entry2`  in  2  register index.
- `out_ready`  in  1  processor can take an instruction this cycle.
- `issue_valid`  out  1  `opcode`/`entry1`/`entry2` hold a new instruction for exactly this cycle.
- `opcode`  out  2  issued opcode (registered).
- `entry1`  out  10  issued memory index (registered).
- `entry2`  out  2  issued register index (registered).
- `count`  out  clog2(DEPTH)+1  instructions queued.
- `empty` / `full`  out  1  `count==0` / `count==DEPTH`.
- `drop_pulse`  out  1  one-cycle pulse when an illegal instruction is discarded.
- `drop_count`  out  8  discarded-instruction counter; saturates at 255.

## Operation
- **Reset values:** while `rst_n`=0, all outputs are 0 except `empty`=1. The FIFO pointers, count and gap counter are cleared.
- **Accept:** an instruction is accepted on any edge where `in_valid && in_ready`.
  - If `in_entry1 > 511`, it is discarded rather than enqueued. `drop_pulse`=1 for the following cycle and `drop_count` increments, saturating at 255.
  - If `in_entry1 ≤ 511`, it is written at the tail.
- **Issue condition:** on an edge where `!empty && out_ready && gap_cnt==0 && !flush`, the head is popped.
  - The popped instruction is registered onto `opcode`/`entry1`/`entry2`, and `issue_valid`=1 for one cycle.
  - On any other edge, `issue_valid`=0 and the output fields hold their last values.
  - The processor acts only in cycles with `issue_valid`=1.
- **Gap counter:** issuing opcode 10 or 11 loads `gap_cnt` with `GAP`. It decrements by 1 on each following edge until 0. Issue is blocked while it is non-zero.
- **Simultaneous push and pop:** both happen in the same cycle; `count` is unchanged.
- **Full:** because `in_ready` is low, no push occurs; a pop on the same edge makes `full` drop for the next cycle.
- **Empty:** a push cannot be issued on the same edge (no fall-through).
- **Flush:** clears the FIFO and `gap_cnt` on that edge. Any simultaneous push is ignored, since `in_ready`=0. `issue_valid`=0 in the next cycle. `drop_count` is retained.
- **Reset mid-operation:** everything clears immediately and asynchronously, with no partial issue.
- **Pointers:** wrap modulo `DEPTH`. `count` is a separate register with DEPTH+1 states.

## Timing
- **Accept-to-issue latency:** accept at edge k gives the earliest `issue_valid` in the cycle after edge k+1, when the queue was empty, `out_ready`=1 and the gap is idle.
- **Throughput:** one instruction per cycle for load/store streams.
- **Gap timing:** a `mul`/`sum` issued at edge t means the next issue is possible no earlier than edge t+GAP+1.
- **`drop_pulse`:** asserted in the cycle after the accepting edge.
- **`count`, `empty`, `full`:** registered; they reflect the push/pop of the previous edge.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_valid`=1 → `in_ready`=0, `issue_valid`=0, `count`=0, `empty`=1, `drop_count`=0. Release → `in_ready`=1.
- **Streaming:** push load(e1=5,e2=0), load(21,1), store(40,2) on consecutive edges 1–3 with `out_ready`=1 → `issue_valid` after edges 2, 3, 4 with fields (00,5,0), (00,21,1), (01,40,2); `count` peaks at 1.
- **Gap:** with `GAP`=2, queue mul, sum, store(0,3) → issues at edges t, t+3, t+6; `issue_valid` low in between.
- **Full/backpressure:** `out_ready`=0, push 9 instructions with `DEPTH`=8.
  - After 8 pushes: `full`=1, `in_ready`=0; the 9th is held upstream.
  - Set `out_ready`=1: the 8 drain in order, then the 9th is accepted and issued.
- **Drop:** push load(e1=600), then load(e1=511) → `drop_pulse` for one cycle, `drop_count`=1, only e1=511 issued. Push 300 illegal instructions → `drop_count`=255.
- **Flush/reset mid-stream:**
  - Queue 5 with `out_ready`=0, then assert `flush` together with `in_valid` → `count`=0, no issue, pushed instruction lost, `drop_count` unchanged.
  - Repeat with async `rst_n` low mid-cycle → outputs 0 immediately.
